// File: rtl/pipeline_hazard_controller.sv
// Pipeline hazard controller: drives PC / IF-ID / ID-EX enables and clears for
// load-use stalls, taken-branch flushes and multi-cycle execute ops.
// Optional perf counters are built when PIPELINE_PERF_COUNTERS_EN is defined.
module pipeline_hazard_controller #(
  parameter int LOAD_DELAY     = 1,
  parameter int BRANCH_BUBBLES = 1,
  parameter int REG_BITS       = 5
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                halt,
  input  logic [REG_BITS-1:0] decode_rs,
  input  logic [REG_BITS-1:0] decode_rt,
  input  logic                decode_uses_rs,
  input  logic                decode_uses_rt,
  input  logic [REG_BITS-1:0] execute_rd,
  input  logic                execute_is_load,
  input  logic                execute_branch_taken,
  input  logic                execute_busy,
  output logic                pc_enable,
  output logic                pc_branch_select,
  output logic                fd_enable,
  output logic                fd_reset,
  output logic                de_enable,
  output logic                de_reset,
  output logic [31:0]         stall_count,
  output logic [31:0]         flush_count
);

  localparam logic [1:0] RUN       = 2'd0;
  localparam logic [1:0] LOADSTALL = 2'd1;
  localparam logic [1:0] FLUSH     = 2'd2;
  localparam logic [1:0] BUSY      = 2'd3;

  localparam logic [2:0] BR_CNT = (BRANCH_BUBBLES > 0) ? 3'(BRANCH_BUBBLES - 1) : 3'd0;
  localparam logic [2:0] LD_CNT = (LOAD_DELAY > 1) ? 3'(LOAD_DELAY - 2) : 3'd0;

  logic [1:0] state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       hz;

  // Register r0 is hardwired zero, so a load into it never creates a hazard.
  assign hz = execute_is_load && (execute_rd != '0) &&
              ((decode_uses_rs && (decode_rs == execute_rd)) ||
               (decode_uses_rt && (decode_rt == execute_rd)));

  always_comb begin
    pc_enable        = 1'b1;
    pc_branch_select = 1'b0;
    fd_enable        = 1'b1;
    fd_reset         = 1'b0;
    de_enable        = 1'b1;
    de_reset         = 1'b0;
    state_d          = state_q;
    cnt_d            = cnt_q;
    if (reset) begin
      pc_enable = 1'b0;
      fd_enable = 1'b0;
      de_enable = 1'b0;
      fd_reset  = 1'b1;
      de_reset  = 1'b1;
      state_d   = RUN;
      cnt_d     = 3'd0;
    end else if (halt) begin
      pc_enable = 1'b0;
      fd_enable = 1'b0;
      de_enable = 1'b0;
    end else begin
      case (state_q)
        LOADSTALL: begin
          pc_enable = 1'b0;
          fd_enable = 1'b0;
          de_reset  = 1'b1;
          if (cnt_q == 3'd0) state_d = RUN;
          else               cnt_d   = cnt_q - 3'd1;
        end
        FLUSH: begin
          fd_reset = 1'b1;
          de_reset = 1'b1;
          if (cnt_q == 3'd0) state_d = RUN;
          else               cnt_d   = cnt_q - 3'd1;
        end
        default: begin
          // BUSY falls through to the RUN evaluation on its completion cycle.
          if (execute_branch_taken) begin
            pc_branch_select = 1'b1;
            fd_reset         = 1'b1;
            de_reset         = 1'b1;
            if (BRANCH_BUBBLES > 0) begin
              state_d = FLUSH;
              cnt_d   = BR_CNT;
            end else begin
              state_d = RUN;
            end
          end else if (execute_busy) begin
            pc_enable = 1'b0;
            fd_enable = 1'b0;
            de_enable = 1'b0;
            state_d   = BUSY;
          end else if (hz) begin
            pc_enable = 1'b0;
            fd_enable = 1'b0;
            de_reset  = 1'b1;
            if (LOAD_DELAY > 1) begin
              state_d = LOADSTALL;
              cnt_d   = LD_CNT;
            end else begin
              state_d = RUN;
            end
          end else begin
            state_d = RUN;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef PIPELINE_PERF_COUNTERS_EN
  logic [31:0] stall_q, flush_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_q <= 32'h0;
      flush_q <= 32'h0;
    end else begin
      if (!pc_enable && !halt && (stall_q != 32'hFFFF_FFFF)) stall_q <= stall_q + 32'h1;
      if (fd_reset && (flush_q != 32'hFFFF_FFFF))            flush_q <= flush_q + 32'h1;
    end
  end

  assign stall_count = stall_q;
  assign flush_count = flush_q;
`else
  assign stall_count = 32'h0;
  assign flush_count = 32'h0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Scoreboard bench for pipeline_hazard_controller: per-cycle expected controls
// are queued with each stimulus and compared at the following falling edge.
module tb_pipeline_hazard_controller;

  localparam int LD = 2;
  localparam int BB = 2;
`ifdef PIPELINE_PERF_COUNTERS_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // Output vector order: {pc_en, br_sel, fd_en, fd_rst, de_en, de_rst}
  localparam logic [5:0] O_DEF   = 6'b101010;
  localparam logic [5:0] O_RST   = 6'b000101;
  localparam logic [5:0] O_FRZ   = 6'b000000;
  localparam logic [5:0] O_BR    = 6'b111111;
  localparam logic [5:0] O_HZ    = 6'b000011;
  localparam logic [5:0] O_FLUSH = 6'b101111;

  typedef struct packed {
    logic       rst, hlt, br, bsy, ld;
    logic [4:0] rd, rs, rt;
    logic       urs, urt;
  } stim_t;

  typedef struct {
    logic [5:0]  o;
    logic [31:0] stall;
    logic [31:0] flush;
    bit          chkCnt;
  } exp_t;

  logic clock = 1'b0;
  logic reset, halt, decode_uses_rs, decode_uses_rt;
  logic execute_is_load, execute_branch_taken, execute_busy;
  logic [4:0] decode_rs, decode_rt, execute_rd;
  logic pc_enable, pc_branch_select, fd_enable, fd_reset, de_enable, de_reset;
  logic [31:0] stall_count, flush_count;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] expStall = 32'h0;
  logic [31:0] expFlush = 32'h0;
  exp_t sbQ[$];

  always #5 clock = ~clock;

  pipeline_hazard_controller #(.LOAD_DELAY(LD), .BRANCH_BUBBLES(BB), .REG_BITS(5)) dut (
    .clock(clock), .reset(reset), .halt(halt),
    .decode_rs(decode_rs), .decode_rt(decode_rt),
    .decode_uses_rs(decode_uses_rs), .decode_uses_rt(decode_uses_rt),
    .execute_rd(execute_rd), .execute_is_load(execute_is_load),
    .execute_branch_taken(execute_branch_taken), .execute_busy(execute_busy),
    .pc_enable(pc_enable), .pc_branch_select(pc_branch_select),
    .fd_enable(fd_enable), .fd_reset(fd_reset),
    .de_enable(de_enable), .de_reset(de_reset),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  function automatic stim_t st(input logic rst, hlt, br, bsy, ld,
                               input logic [4:0] rd, rs, rt, input logic urs, urt);
    stim_t s;
    s = '{rst, hlt, br, bsy, ld, rd, rs, rt, urs, urt};
    return s;
  endfunction

  // Drives one cycle of inputs and queues what the controller must show for it.
  task automatic applyStimulus(input stim_t s, input logic [5:0] eo, input bit chkCnt);
    exp_t e;
    reset = s.rst; halt = s.hlt; execute_branch_taken = s.br; execute_busy = s.bsy;
    execute_is_load = s.ld; execute_rd = s.rd; decode_rs = s.rs; decode_rt = s.rt;
    decode_uses_rs = s.urs; decode_uses_rt = s.urt;
    e.o = eo; e.stall = expStall; e.flush = expFlush; e.chkCnt = chkCnt;
    sbQ.push_back(e);
    if (s.rst) begin
      expStall = 32'h0;
      expFlush = 32'h0;
    end else if (PERF) begin
      if (!eo[5] && !s.hlt && expStall != 32'hFFFF_FFFF) expStall = expStall + 32'h1;
      if (eo[2] && expFlush != 32'hFFFF_FFFF)           expFlush = expFlush + 32'h1;
    end
  endtask

  task automatic test_reset();
    exp_t e;
    logic [5:0] act;
    stim_t s[3];
    logic [5:0] x[3];
    s[0] = st(1,0,1,1,1,5'd5,5'd5,5'd5,1,1); x[0] = O_RST;
    s[1] = st(1,0,0,0,0,0,0,0,0,0);          x[1] = O_RST;
    s[2] = st(0,0,0,0,0,0,0,0,0,0);          x[2] = O_DEF;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(s[i], x[i], i != 0);
      @(negedge clock);
      e = sbQ.pop_front();
      act = {pc_enable, pc_branch_select, fd_enable, fd_reset, de_enable, de_reset};
      vectors++;
      if (act !== e.o) begin
        miscompares++;
        $display("[TB] FAIL reset[%0d] ctrl actual=%b required=%b", i, act, e.o);
      end
      if (e.chkCnt) begin
        vectors++;
        if (stall_count !== e.stall || flush_count !== e.flush) begin
          miscompares++;
          $display("[TB] FAIL reset[%0d] counters actual=%0d/%0d required=%0d/%0d",
                   i, stall_count, flush_count, e.stall, e.flush);
        end
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_load_use();
    exp_t e;
    logic [5:0] act;
    stim_t s[9];
    logic [5:0] x[9];
    s[0] = st(0,0,0,0,1,5'd5,5'd5,5'd9,1,0); x[0] = O_HZ;
    s[1] = st(0,0,0,0,0,0,0,0,0,0);          x[1] = O_HZ;
    s[2] = st(0,0,0,0,0,0,0,0,0,0);          x[2] = O_DEF;
    s[3] = st(0,0,0,0,1,5'd7,5'd3,5'd7,0,1); x[3] = O_HZ;
    s[4] = st(0,0,0,0,1,5'd7,5'd3,5'd7,0,1); x[4] = O_HZ;
    s[5] = st(0,0,0,0,0,0,0,0,0,0);          x[5] = O_DEF;
    s[6] = st(0,0,0,0,1,5'd6,5'd6,5'd6,0,0); x[6] = O_DEF;
    s[7] = st(0,0,0,0,0,5'd4,5'd4,5'd0,1,0); x[7] = O_DEF;
    s[8] = st(0,0,0,0,1,5'd0,5'd0,5'd0,1,1); x[8] = O_DEF;
    for (int i = 0; i < 9; i++) begin
      applyStimulus(s[i], x[i], 1'b1);
      @(negedge clock);
      e = sbQ.pop_front();
      act = {pc_enable, pc_branch_select, fd_enable, fd_reset, de_enable, de_reset};
      vectors++;
      if (act !== e.o) begin
        miscompares++;
        $display("[TB] FAIL load_use[%0d] ctrl actual=%b required=%b", i, act, e.o);
      end
      vectors++;
      if (stall_count !== e.stall || flush_count !== e.flush) begin
        miscompares++;
        $display("[TB] FAIL load_use[%0d] counters actual=%0d/%0d required=%0d/%0d",
                 i, stall_count, flush_count, e.stall, e.flush);
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_branch();
    exp_t e;
    logic [5:0] act;
    stim_t s[5];
    logic [5:0] x[5];
    s[0] = st(0,0,1,0,0,0,0,0,0,0);          x[0] = O_BR;
    s[1] = st(0,0,1,1,1,5'd2,5'd2,5'd2,1,1); x[1] = O_FLUSH;
    s[2] = st(0,0,0,0,0,0,0,0,0,0);          x[2] = O_FLUSH;
    s[3] = st(0,0,0,0,0,0,0,0,0,0);          x[3] = O_DEF;
    s[4] = st(0,0,0,0,0,0,0,0,0,0);          x[4] = O_DEF;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(s[i], x[i], 1'b1);
      @(negedge clock);
      e = sbQ.pop_front();
      act = {pc_enable, pc_branch_select, fd_enable, fd_reset, de_enable, de_reset};
      vectors++;
      if (act !== e.o) begin
        miscompares++;
        $display("[TB] FAIL branch[%0d] ctrl actual=%b required=%b", i, act, e.o);
      end
      vectors++;
      if (stall_count !== e.stall || flush_count !== e.flush) begin
        miscompares++;
        $display("[TB] FAIL branch[%0d] counters actual=%0d/%0d required=%0d/%0d",
                 i, stall_count, flush_count, e.stall, e.flush);
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_busy();
    exp_t e;
    logic [5:0] act;
    stim_t s[13];
    logic [5:0] x[13];
    for (int i = 0; i < 4; i++) begin
      s[i] = st(0,0,0,1,0,0,0,0,0,0); x[i] = O_FRZ;
    end
    s[4]  = st(0,0,1,0,0,0,0,0,0,0);          x[4]  = O_BR;
    s[5]  = st(0,0,0,0,0,0,0,0,0,0);          x[5]  = O_FLUSH;
    s[6]  = st(0,0,0,0,0,0,0,0,0,0);          x[6]  = O_FLUSH;
    s[7]  = st(0,0,0,0,0,0,0,0,0,0);          x[7]  = O_DEF;
    s[8]  = st(0,0,0,1,1,5'd8,5'd8,5'd0,1,0); x[8]  = O_FRZ;
    s[9]  = st(0,0,0,0,1,5'd8,5'd8,5'd0,1,0); x[9]  = O_HZ;
    s[10] = st(0,0,0,0,0,0,0,0,0,0);          x[10] = O_HZ;
    s[11] = st(0,0,0,0,0,0,0,0,0,0);          x[11] = O_DEF;
    s[12] = st(0,0,0,0,0,0,0,0,0,0);          x[12] = O_DEF;
    for (int i = 0; i < 13; i++) begin
      applyStimulus(s[i], x[i], 1'b1);
      @(negedge clock);
      e = sbQ.pop_front();
      act = {pc_enable, pc_branch_select, fd_enable, fd_reset, de_enable, de_reset};
      vectors++;
      if (act !== e.o) begin
        miscompares++;
        $display("[TB] FAIL busy[%0d] ctrl actual=%b required=%b", i, act, e.o);
      end
      vectors++;
      if (stall_count !== e.stall || flush_count !== e.flush) begin
        miscompares++;
        $display("[TB] FAIL busy[%0d] counters actual=%0d/%0d required=%0d/%0d",
                 i, stall_count, flush_count, e.stall, e.flush);
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_priority();
    exp_t e;
    logic [5:0] act;
    stim_t s[5];
    logic [5:0] x[5];
    s[0] = st(0,0,1,1,1,5'd3,5'd3,5'd3,1,1); x[0] = O_BR;
    s[1] = st(0,0,0,0,0,0,0,0,0,0);          x[1] = O_FLUSH;
    s[2] = st(0,0,0,0,0,0,0,0,0,0);          x[2] = O_FLUSH;
    s[3] = st(0,0,0,1,1,5'd3,5'd3,5'd3,1,1); x[3] = O_FRZ;
    s[4] = st(0,0,0,0,0,0,0,0,0,0);          x[4] = O_DEF;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(s[i], x[i], 1'b1);
      @(negedge clock);
      e = sbQ.pop_front();
      act = {pc_enable, pc_branch_select, fd_enable, fd_reset, de_enable, de_reset};
      vectors++;
      if (act !== e.o) begin
        miscompares++;
        $display("[TB] FAIL priority[%0d] ctrl actual=%b required=%b", i, act, e.o);
      end
      vectors++;
      if (stall_count !== e.stall || flush_count !== e.flush) begin
        miscompares++;
        $display("[TB] FAIL priority[%0d] counters actual=%0d/%0d required=%0d/%0d",
                 i, stall_count, flush_count, e.stall, e.flush);
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_halt();
    exp_t e;
    logic [5:0] act;
    stim_t s[5];
    logic [5:0] x[5];
    s[0] = st(0,0,0,0,1,5'd9,5'd1,5'd9,0,1); x[0] = O_HZ;
    s[1] = st(0,1,1,1,0,0,0,0,0,0);          x[1] = O_FRZ;
    s[2] = st(0,1,0,0,0,0,0,0,0,0);          x[2] = O_FRZ;
    s[3] = st(0,0,0,0,0,0,0,0,0,0);          x[3] = O_HZ;
    s[4] = st(0,0,0,0,0,0,0,0,0,0);          x[4] = O_DEF;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(s[i], x[i], 1'b1);
      @(negedge clock);
      e = sbQ.pop_front();
      act = {pc_enable, pc_branch_select, fd_enable, fd_reset, de_enable, de_reset};
      vectors++;
      if (act !== e.o) begin
        miscompares++;
        $display("[TB] FAIL halt[%0d] ctrl actual=%b required=%b", i, act, e.o);
      end
      vectors++;
      if (stall_count !== e.stall || flush_count !== e.flush) begin
        miscompares++;
        $display("[TB] FAIL halt[%0d] counters actual=%0d/%0d required=%0d/%0d",
                 i, stall_count, flush_count, e.stall, e.flush);
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_reset_mid_flush();
    exp_t e;
    logic [5:0] act;
    stim_t s[5];
    logic [5:0] x[5];
    s[0] = st(0,0,1,0,0,0,0,0,0,0);          x[0] = O_BR;
    s[1] = st(1,0,1,0,0,0,0,0,0,0);          x[1] = O_RST;
    s[2] = st(0,0,0,0,0,0,0,0,0,0);          x[2] = O_DEF;
    s[3] = st(0,0,0,0,1,5'd4,5'd4,5'd0,1,0); x[3] = O_HZ;
    s[4] = st(1,0,0,0,0,0,0,0,0,0);          x[4] = O_RST;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(s[i], x[i], 1'b1);
      @(negedge clock);
      e = sbQ.pop_front();
      act = {pc_enable, pc_branch_select, fd_enable, fd_reset, de_enable, de_reset};
      vectors++;
      if (act !== e.o) begin
        miscompares++;
        $display("[TB] FAIL reset_mid[%0d] ctrl actual=%b required=%b", i, act, e.o);
      end
      vectors++;
      if (stall_count !== e.stall || flush_count !== e.flush) begin
        miscompares++;
        $display("[TB] FAIL reset_mid[%0d] counters actual=%0d/%0d required=%0d/%0d",
                 i, stall_count, flush_count, e.stall, e.flush);
      end
      @(posedge clock); #1;
    end
    // After reset in LOADSTALL the controller must be back in RUN at once.
    applyStimulus(st(0,0,0,0,0,0,0,0,0,0), O_DEF, 1'b1);
    @(negedge clock);
    e = sbQ.pop_front();
    act = {pc_enable, pc_branch_select, fd_enable, fd_reset, de_enable, de_reset};
    vectors++;
    if (act !== e.o || stall_count !== e.stall || flush_count !== e.flush) begin
      miscompares++;
      $display("[TB] FAIL post_reset ctrl=%b cnt=%0d/%0d required ctrl=%b cnt=%0d/%0d",
               act, stall_count, flush_count, e.o, e.stall, e.flush);
    end
    @(posedge clock); #1;
  endtask

  initial begin
    reset = 1'b1; halt = 1'b0; execute_branch_taken = 1'b0; execute_busy = 1'b0;
    execute_is_load = 1'b0; execute_rd = '0; decode_rs = '0; decode_rt = '0;
    decode_uses_rs = 1'b0; decode_uses_rt = 1'b0;
    #1;
    test_reset();
    test_load_use();
    test_branch();
    test_busy();
    test_priority();
    test_halt();
    test_reset_mid_flush();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
- Sequences the fetch/decode and decode/execute pipeline registers plus the PC register by driving their enable and reset inputs.
- Detects load-use hazards, taken branches resolved in execute, and multi-cycle execute ops.
- Emits stall, bubble and flush controls through a small FSM with a bubble counter.
- Sits beside the pipeline registers; consumes pre-extracted register fields only, no ISA decode.

Parameters:
- LOAD_DELAY, 1, bubble cycles inserted per load-use hazard (1..7).
- BRANCH_BUBBLES, 1, extra flush cycles after the taken-branch cycle (0..7).
- REG_BITS, 5, register-specifier width.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- halt  in  1  freeze pipeline and FSM.
- decode_rs  in  REG_BITS  source A of instruction in decode.
- decode_rt  in  REG_BITS  source B of instruction in decode.
- decode_uses_rs  in  1  decode reads rs.
- decode_uses_rt  in  1  decode reads rt.
- execute_rd  in  REG_BITS  destination of instruction in execute.
- execute_is_load  in  1  execute holds a load.
- execute_branch_taken  in  1  execute resolved a taken branch.
- execute_busy  in  1  multi-cycle op in execute not yet done.
- pc_enable  out  1  PC register enable.
- pc_branch_select  out  1  PC loads branch address.
- fd_enable  out  1  fetch/decode register enable.
- fd_reset  out  1  fetch/decode register clear.
- de_enable  out  1  decode/execute register enable.
- de_reset  out  1  decode/execute register clear (bubble).
- stall_count  out  32  perf counter (optional feature).
- flush_count  out  32  perf counter (optional feature).

Behaviour:
- FSM states: RUN=0, LOADSTALL=1, FLUSH=2, BUSY=3. 3-bit down-counter cnt.
- Outputs are combinational from state and inputs, so the response is zero-latency. State and cnt are registered.
- Reset (reset=1, synchronous):
  - next state RUN, cnt=0.
  - While reset is high: pc_enable=fd_enable=de_enable=0, fd_reset=de_reset=1, pc_branch_select=0.
- Default, no event: all enables 1, all resets 0, pc_branch_select=0.
- halt=1 (reset=0): all enables 0, resets 0, pc_branch_select=0; state and cnt hold; all other inputs ignored.
- Hazard term: hz = execute_is_load & (execute_rd!=0) & ((decode_uses_rs & decode_rs==execute_rd) | (decode_uses_rt & decode_rt==execute_rd)).
- RUN, priority order branch > busy > hazard:
  - execute_branch_taken: pc_branch_select=1, pc_enable=1, fd_reset=1, de_reset=1, fd_enable=de_enable=1. If BRANCH_BUBBLES>0, go to FLUSH with cnt=BRANCH_BUBBLES-1; else stay RUN.
  - execute_busy: pc_enable=fd_enable=de_enable=0; go to BUSY.
  - hz: pc_enable=fd_enable=0, de_enable=1, de_reset=1. If LOAD_DELAY>1, go to LOADSTALL with cnt=LOAD_DELAY-2; else stay RUN.
- LOADSTALL: same outputs as the hz case; branch/busy/hz inputs ignored. If cnt==0 go to RUN, else cnt-=1.
- FLUSH: pc_enable=1, fd_reset=de_reset=1, pc_branch_select=0; branch input ignored. If cnt==0 go to RUN, else cnt-=1.
- BUSY:
  - While execute_busy=1: all enables 0.
  - On the cycle execute_busy=0: evaluate exactly as RUN (outputs and next state), so a branch or hazard at completion is honoured the same cycle.
- cnt never wraps; it only decrements when nonzero.
- Reset mid-LOADSTALL/FLUSH/BUSY: abandon immediately; next state RUN.

Optional Feature:
- Macro: PIPELINE_PERF_COUNTERS_EN.
- Defined:
  - stall_count +1 on each cycle with pc_enable=0, halt=0, reset=0.
  - flush_count +1 on each cycle with fd_reset=1, reset=0.
  - Both saturate at 32'hFFFFFFFF and clear to 0 on reset.
- Undefined: no counter logic; both ports tied to 32'h0. Ports present in both builds.

Test Plan:
- Load-use, LOAD_DELAY=1: execute_is_load=1, execute_rd=5, decode_rs=5, decode_uses_rs=1 for one cycle -> that cycle pc_enable=0, fd_enable=0, de_reset=1; next cycle (hz cleared) all enables 1; stall_count=1.
- No hazard on r0: execute_rd=0 with matching decode_rs=0 -> no stall, outputs default.
- Taken branch, BRANCH_BUBBLES=2: execute_branch_taken=1 in RUN -> pc_branch_select=1, fd_reset=de_reset=1 that cycle, then 2 more FLUSH cycles with pc_branch_select=0, then RUN; flush_count=3.
- Busy then branch: execute_busy=1 for 4 cycles -> enables 0 for 4 cycles. Busy falls with execute_branch_taken=1 -> same cycle pc_branch_select=1 and flush begins.
- Simultaneous branch+hz+busy in RUN -> branch response only; hz and busy ignored.
- Reset mid-FLUSH (BRANCH_BUBBLES=3, reset on 2nd flush cycle) -> reset-cycle outputs as specified; first post-reset cycle in RUN with default outputs; counters 0.
